wrclk_port_arbiter: RTL and testbench

Round-robin arbiter that shares one registered write port between NREQ requesters. Each requester raises a request, gets an exclusive one-hot grant, and streams one data word per cycle until it drops its request or reaches a hold limit. The block sits in front of the single-clock state/update logic clocked by the write clock and serialises all writers onto that one port. After every grant the arbiter inserts one idle gap cycle.

---
 rtl/wrclk_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wrclk_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wrclk_port_arbiter.sv
// -----------------------------------------------------------------------------
// wrclk_port_arbiter
//
// Round-robin arbiter that serialises NREQ writers onto one registered write
// port. A requester holds i_req high to ask for the port. Once granted (o_gnt
// one-hot), it streams one word per cycle on its i_data lane. It keeps the
// port until it drops i_req or has made MAXHOLD transfers. Every grant is
// followed by exactly one idle GAP cycle before the next grant.
//
// Handshake: a transfer is accepted in any GRANT cycle where
// i_req[o_owner] is high (i_req acts as valid, the registered o_gnt acts as
// ready). The accepted word appears on o_data with o_valid high after the edge
// that ends that cycle. o_data holds its last value while o_valid is low.
//
// Parameters:
//   NREQ     number of requesters (2..16)
//   DW       data word width
//   MAXHOLD  maximum transfers per grant (>= 1)
//
// Ports:
//   i_clk    write clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_req    per-requester request, bit k = requester k
//   i_data   per-requester data, requester k on [k*DW +: DW]
//   o_gnt    registered one-hot grant, zero when no grant is active
//   o_owner  index of the current or most recent grantee
//   o_valid  one transfer was accepted on the previous cycle
//   o_data   data of the accepted transfer
//   o_busy   FSM is not in IDLE
//   o_state  FSM state for debug (00 IDLE, 01 GRANT, 10 GAP)
// -----------------------------------------------------------------------------
module wrclk_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int MAXHOLD = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*DW-1:0]       i_data,
    output logic [NREQ-1:0]          o_gnt,
    output logic [$clog2(NREQ)-1:0]  o_owner,
    output logic                     o_valid,
    output logic [DW-1:0]            o_data,
    output logic                     o_busy,
    output logic [1:0]               o_state
);

    localparam int OW = $clog2(NREQ);
    localparam int HW = $clog2(MAXHOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [HW-1:0]   hold;
    logic [HW-1:0]   hold_inc;

    logic            any_req;
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0] req_rot;
    logic [OW-1:0]   win;
    logic [OW:0]     win_sum;
    logic            found;
    logic [OW-1:0]   ptr_next;
    logic [NREQ-1:0] win_onehot;
    logic [DW-1:0]   owner_data;

    assign any_req  = |i_req;
    assign hold_inc = hold + HW'(1);

    // Rotate the request vector so that bit 0 is the requester at ptr; the
    // first set bit of the rotated vector is the round-robin winner.
    assign req_dbl = {i_req, i_req} >> ptr;
    assign req_rot = req_dbl[NREQ-1:0];

    always_comb begin
        win     = '0;
        win_sum = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_rot[i]) begin
                found   = 1'b1;
                win_sum = {1'b0, ptr} + (OW+1)'(i);
                if (win_sum >= (OW+1)'(NREQ)) begin
                    win_sum = win_sum - (OW+1)'(NREQ);
                end
                win = win_sum[OW-1:0];
            end
        end
    end

    // Pointer moves to the requester after the winner, wrapping NREQ-1 -> 0.
    assign ptr_next   = (win == OW'(NREQ - 1)) ? '0 : win + OW'(1);
    assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win;

    always_comb begin
        owner_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (o_owner == OW'(k)) begin
                owner_data = i_data[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            hold    <= '0;
            o_gnt   <= '0;
            o_owner <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (any_req) begin
                        state   <= GRANT;
                        o_owner <= win;
                        ptr     <= ptr_next;
                        o_gnt   <= win_onehot;
                        hold    <= '0;
                    end else begin
                        state <= IDLE;
                        o_gnt <= '0;
                    end
                end
                GRANT: begin
                    if (i_req[o_owner]) begin
                        o_valid <= 1'b1;
                        o_data  <= owner_data;
                        hold    <= hold_inc;
                        // Release after the transfer that reaches the limit.
                        if (hold_inc == HW'(MAXHOLD)) begin
                            state <= GAP;
                            o_gnt <= '0;
                        end
                    end else begin
                        // Owner dropped its request: no transfer this cycle.
                        state <= GAP;
                        o_gnt <= '0;
                    end
                end
                default: begin
                    // Unused encoding 2'b11 recovers to IDLE.
                    state <= IDLE;
                    o_gnt <= '0;
                end
            endcase
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_state = state;

endmodule

// File: tb/tb_wrclk_port_arbiter.sv
module tb_wrclk_port_arbiter;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: NREQ=4, DW=8, MAXHOLD=4
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        valid;
    logic [7:0]  dout;
    logic        busy;
    logic [1:0]  state;

    // DUT B: NREQ=2, DW=8, MAXHOLD=1
    logic [1:0]  req_b;
    logic [15:0] data_b;
    logic [1:0]  gnt_b;
    logic [0:0]  owner_b;
    logic        valid_b;
    logic [7:0]  dout_b;
    logic        busy_b;
    logic [1:0]  state_b;

    wrclk_port_arbiter #(.NREQ(4), .DW(8), .MAXHOLD(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .i_data  (data),
        .o_gnt   (gnt),
        .o_owner (owner),
        .o_valid (valid),
        .o_data  (dout),
        .o_busy  (busy),
        .o_state (state)
    );

    wrclk_port_arbiter #(.NREQ(2), .DW(8), .MAXHOLD(1)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req_b),
        .i_data  (data_b),
        .o_gnt   (gnt_b),
        .o_owner (owner_b),
        .o_valid (valid_b),
        .o_data  (dout_b),
        .o_busy  (busy_b),
        .o_state (state_b)
    );

    // ---------------------------------------------------------------- checking
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic        valid;
        logic [7:0]  dout;
        logic [1:0]  owner;
        logic [1:0]  state;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    // Background data has a distinct byte on every lane; one lane is overridden.
    function automatic logic [31:0] lane(input int k, input logic [7:0] v);
        logic [31:0] r;
        r = 32'hF3E2D1C0;
        r[k*8 +: 8] = v;
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d,
                                input logic [3:0] g, input logic v,
                                input logic [7:0] o, input logic [1:0] ow,
                                input logic [1:0] s);
        vec_t x;
        x.req = r; x.data = d; x.gnt = g; x.valid = v;
        x.dout = o; x.owner = ow; x.state = s;
        return x;
    endfunction

    initial begin
        // Single requester 2 running to MAXHOLD, one gap, re-grant.
        vecs[0]  = mk(4'b0100, lane(2, 8'h10), 4'b0100, 1'b0, 8'h00, 2'd2, 2'd1);
        vecs[1]  = mk(4'b0100, lane(2, 8'h10), 4'b0100, 1'b1, 8'h10, 2'd2, 2'd1);
        vecs[2]  = mk(4'b0100, lane(2, 8'h11), 4'b0100, 1'b1, 8'h11, 2'd2, 2'd1);
        vecs[3]  = mk(4'b0100, lane(2, 8'h12), 4'b0100, 1'b1, 8'h12, 2'd2, 2'd1);
        vecs[4]  = mk(4'b0100, lane(2, 8'h13), 4'b0000, 1'b1, 8'h13, 2'd2, 2'd2);
        vecs[5]  = mk(4'b0100, lane(2, 8'h14), 4'b0100, 1'b0, 8'h13, 2'd2, 2'd1);
        vecs[6]  = mk(4'b0100, lane(2, 8'h14), 4'b0100, 1'b1, 8'h14, 2'd2, 2'd1);
        vecs[7]  = mk(4'b0000, lane(2, 8'h15), 4'b0000, 1'b0, 8'h14, 2'd2, 2'd2);
        vecs[8]  = mk(4'b0000, lane(2, 8'h15), 4'b0000, 1'b0, 8'h14, 2'd2, 2'd0);
        vecs[9]  = mk(4'b0000, lane(2, 8'h15), 4'b0000, 1'b0, 8'h14, 2'd2, 2'd0);
        // Early drop by requester 1 after 2 transfers; pending 3 then granted.
        vecs[10] = mk(4'b0010, lane(1, 8'h20), 4'b0010, 1'b0, 8'h14, 2'd1, 2'd1);
        vecs[11] = mk(4'b1010, lane(1, 8'h20), 4'b0010, 1'b1, 8'h20, 2'd1, 2'd1);
        vecs[12] = mk(4'b1010, lane(1, 8'h21), 4'b0010, 1'b1, 8'h21, 2'd1, 2'd1);
        vecs[13] = mk(4'b1000, lane(1, 8'h22), 4'b0000, 1'b0, 8'h21, 2'd1, 2'd2);
        vecs[14] = mk(4'b1000, lane(3, 8'h30), 4'b1000, 1'b0, 8'h21, 2'd3, 2'd1);
        // Non-owners 0 and 2 request while 3 owns; then 0 (wrap), then 2.
        vecs[15] = mk(4'b1101, lane(3, 8'h30), 4'b1000, 1'b1, 8'h30, 2'd3, 2'd1);
        vecs[16] = mk(4'b1101, lane(3, 8'h31), 4'b1000, 1'b1, 8'h31, 2'd3, 2'd1);
        vecs[17] = mk(4'b0101, lane(3, 8'h32), 4'b0000, 1'b0, 8'h31, 2'd3, 2'd2);
        vecs[18] = mk(4'b0101, lane(0, 8'h40), 4'b0001, 1'b0, 8'h31, 2'd0, 2'd1);
        vecs[19] = mk(4'b0100, lane(0, 8'h41), 4'b0000, 1'b0, 8'h31, 2'd0, 2'd2);
        vecs[20] = mk(4'b0100, lane(2, 8'h50), 4'b0100, 1'b0, 8'h31, 2'd2, 2'd1);
        vecs[21] = mk(4'b0000, lane(2, 8'h50), 4'b0000, 1'b0, 8'h31, 2'd2, 2'd2);
        vecs[22] = mk(4'b0000, lane(2, 8'h50), 4'b0000, 1'b0, 8'h31, 2'd2, 2'd0);
    end

    // ---------------------------------------------------------------- test
    initial begin
        int vcount;
        int k;
        req    = '0;
        data   = '0;
        req_b  = '0;
        data_b = '0;

        // Reset defaults
        step();
        step();
        chk("rst_gnt",   0, gnt,   0);
        chk("rst_valid", 0, valid, 0);
        chk("rst_data",  0, dout,  0);
        chk("rst_owner", 0, owner, 0);
        chk("rst_busy",  0, busy,  0);
        chk("rst_state", 0, state, 0);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            req  = vecs[i].req;
            data = vecs[i].data;
            step();
            chk("vec_gnt",   i, gnt,   vecs[i].gnt);
            chk("vec_valid", i, valid, vecs[i].valid);
            chk("vec_data",  i, dout,  vecs[i].dout);
            chk("vec_owner", i, owner, vecs[i].owner);
            chk("vec_state", i, state, vecs[i].state);
            chk("vec_busy",  i, busy,  (vecs[i].state != 2'd0));
        end

        // Request glitch between edges while IDLE has no effect
        #2 req = 4'b0010;
        #4 req = 4'b0000;
        step();
        chk("glitch_gnt",   0, gnt,   0);
        chk("glitch_busy",  0, busy,  0);
        chk("glitch_state", 0, state, 0);

        // Reset mid-grant clears outputs without a clock edge
        data = {8'h63, 8'h62, 8'h61, 8'h60};
        req  = 4'b0100;
        step();
        chk("mid_gnt", 0, gnt, 4'b0100);
        step();
        chk("mid_valid", 0, valid, 1);
        chk("mid_data",  0, dout,  8'h62);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt",   0, gnt,   0);
        chk("arst_valid", 0, valid, 0);
        chk("arst_busy",  0, busy,  0);
        chk("arst_data",  0, dout,  0);
        chk("arst_owner", 0, owner, 0);
        req = 4'b1111;
        step();
        rst_n = 1'b1;

        // Round robin with wrap: 0,1,2,3,0, MAXHOLD pulses each, one-cycle gap
        for (int g = 0; g < 5; g++) begin
            k = g % 4;
            vcount = 0;
            for (int j = 0; j < 4; j++) begin
                step();
                chk("rr_gnt", g, gnt, 4'b0001 << k);
                chk("rr_owner", g, owner, k);
                if (j == 0) begin
                    chk("rr_first_valid", g, valid, 0);
                end else begin
                    chk("rr_data", g, dout, 8'h60 + k);
                end
                if (valid) vcount++;
            end
            step();
            chk("rr_gap_gnt", g, gnt, 0);
            chk("rr_gap_data", g, dout, 8'h60 + k);
            if (valid) vcount++;
            chk("rr_pulses", g, vcount, 4);
        end
        req = 4'b0000;
        step();
        step();
        chk("rr_idle", 0, busy, 0);

        // NREQ=2, MAXHOLD=1: alternate 0,1,0,1 with single pulses and gaps
        data_b = {8'hB1, 8'hB0};
        req_b  = 2'b11;
        for (int g = 0; g < 4; g++) begin
            k = g % 2;
            step();
            chk("p2_gnt",   g, gnt_b,   2'b01 << k);
            chk("p2_owner", g, owner_b, k);
            chk("p2_valid0", g, valid_b, 0);
            step();
            chk("p2_gap_gnt", g, gnt_b,   0);
            chk("p2_valid",   g, valid_b, 1);
            chk("p2_data",    g, dout_b,  (k == 0) ? 8'hB0 : 8'hB1);
        end
        req_b = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
